// File: rtl/tower_game_fsm.sv
// Gameplay controller for the tower-stacking game: sequences rows with a counter,
// tracks chances and score, and drives load/enable strobes for the gameplay datapath.
module tower_game_fsm #(
    parameter int NUM_ROWS   = 7,
    parameter int ROW_W      = 3,
    parameter int Y_BASE     = 104,
    parameter int ROW_HEIGHT = 16,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 144,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int CHANCES    = 3,
    parameter int CH_W       = 2,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s,
    input  logic               p,
    input  logic               o,
    output logic               ld_x,
    output logic               ld_y,
    output logic               ld_d,
    output logic               enable,
    output logic               save_x,
    output logic               new_direction,
    output logic [X_W-1:0]     new_x_position,
    output logic [Y_W-1:0]     new_y_position,
    output logic [1:0]         game_status,
    output logic [ROW_W-1:0]   row,
    output logic [SCORE_W-1:0] score,
    output logic [CH_W-1:0]    chances_left
);

    typedef enum logic [2:0] {
        PREP   = 3'd0,
        MOVE   = 3'd1,
        PAUSED = 3'd2,
        PLACE  = 3'd3,
        WIN    = 3'd4,
        LOSE   = 3'd5
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(NUM_ROWS - 1);
    localparam logic [CH_W-1:0]  CHANCES_INIT = CH_W'(CHANCES);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CH_W-1:0]    chances_q, chances_d;
    logic               s_q, p_q;
    logic               s_rise, p_rise;
    logic               accept;
    logic [Y_W-1:0]     row_y;

    // Key history resets high so a key held through reset is not seen as a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PREP;
            row_q     <= '0;
            score_q   <= '0;
            chances_q <= CHANCES_INIT;
            s_q       <= 1'b1;
            p_q       <= 1'b1;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            score_q   <= score_d;
            chances_q <= chances_d;
            s_q       <= s;
            p_q       <= p;
        end
    end

    assign s_rise = s & ~s_q;
    assign p_rise = p & ~p_q;
    assign accept = (row_q == '0) || o;
    // Modular arithmetic in Y_W bits gives the truncated row height directly.
    assign row_y  = Y_W'(Y_BASE) - Y_W'(row_q) * Y_W'(ROW_HEIGHT);

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        score_d        = score_q;
        chances_d      = chances_q;
        ld_x           = 1'b0;
        ld_y           = 1'b0;
        ld_d           = 1'b0;
        enable         = 1'b0;
        save_x         = 1'b0;
        new_direction  = 1'b0;
        new_x_position = '0;
        new_y_position = '0;
        game_status    = 2'b01;

        case (state_q)
            PREP: begin
                ld_x           = 1'b1;
                ld_y           = 1'b1;
                ld_d           = 1'b1;
                new_direction  = ~row_q[0];
                new_x_position = row_q[0] ? X_W'(X_MAX) : X_W'(X_MIN);
                new_y_position = row_y;
                state_d        = MOVE;
            end
            MOVE: begin
                enable = 1'b1;
                if (p_rise) begin
                    state_d = PAUSED;
                end else if (s_rise) begin
                    state_d = PLACE;
                end
            end
            PAUSED: begin
                game_status = 2'b00;
                if (p_rise) begin
                    state_d = MOVE;
                end
            end
            PLACE: begin
                if (accept) begin
                    save_x = 1'b1;
                    if (row_q != '0 && score_q != '1) begin
                        score_d = score_q + 1'b1;
                    end
                    if (row_q == LAST_ROW) begin
                        state_d = WIN;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = PREP;
                    end
                end else if (chances_q == CH_W'(1)) begin
                    chances_d = '0;
                    state_d   = LOSE;
                end else begin
                    chances_d = chances_q - 1'b1;
                    state_d   = PREP;
                end
            end
            WIN, LOSE: begin
                game_status = (state_q == WIN) ? 2'b10 : 2'b11;
                if (s_rise) begin
                    row_d     = '0;
                    score_d   = '0;
                    chances_d = CHANCES_INIT;
                    state_d   = PREP;
                end
            end
            default: begin
                state_d = PREP;
            end
        endcase
    end

    assign row          = row_q;
    assign score        = score_q;
    assign chances_left = chances_q;

endmodule

// File: tb/tb_tower_game_fsm.sv
// Directed bench for tower_game_fsm: expected values are queued as stimulus is
// driven and popped against the DUT outputs one clock later.
module tb_tower_game_fsm;

    logic       clk = 1'b0;
    logic       reset, s, p, o;
    logic       ld_x, ld_y, ld_d, enable, save_x, new_direction;
    logic [7:0] new_x_position;
    logic [6:0] new_y_position;
    logic [1:0] game_status;
    logic [2:0] row;
    logic [3:0] score;
    logic [1:0] chances_left;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    tower_game_fsm dut (
        .clk(clk), .reset(reset), .s(s), .p(p), .o(o),
        .ld_x(ld_x), .ld_y(ld_y), .ld_d(ld_d), .enable(enable), .save_x(save_x),
        .new_direction(new_direction), .new_x_position(new_x_position),
        .new_y_position(new_y_position), .game_status(game_status),
        .row(row), .score(score), .chances_left(chances_left)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            $display("check %s: observed %0h expected %0h", t, obs, e);
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    // Rising edge on s; returns one cycle later with s low again.
    task automatic press();
        s = 1'b1;
        tick();
        s = 1'b0;
    endtask

    initial begin
        reset = 1'b1; s = 1'b1; p = 1'b0; o = 1'b0;
        push("rst_ld_x", 1); push("rst_ld_y", 1); push("rst_new_y", 104);
        push("rst_new_x", 0); push("rst_dir", 1); push("rst_status", 1);
        push("rst_row", 0); push("rst_score", 0); push("rst_chances", 3);
        push("rst_enable", 0);
        #12;
        pop_chk(32'(ld_x)); pop_chk(32'(ld_y)); pop_chk(32'(new_y_position));
        pop_chk(32'(new_x_position)); pop_chk(32'(new_direction)); pop_chk(32'(game_status));
        pop_chk(32'(row)); pop_chk(32'(score)); pop_chk(32'(chances_left));
        pop_chk(32'(enable));

        // Release reset with s held: PREP for one cycle, then MOVE with no placement.
        @(posedge clk); #1; reset = 1'b0;
        push("prep_ld_d", 1);
        pop_chk(32'(ld_d));
        push("move_enable", 1); push("move_ld_x", 0);
        tick();
        pop_chk(32'(enable)); pop_chk(32'(ld_x));
        push("held_s_no_place", 1);
        tick(); tick();
        pop_chk(32'(enable));

        // Row 0 placement.
        s = 1'b0; tick();
        push("r0_save_x", 1); push("r0_enable", 0);
        press();
        pop_chk(32'(save_x)); pop_chk(32'(enable));
        push("r1_row", 1); push("r1_new_x", 144); push("r1_dir", 0);
        push("r1_new_y", 88); push("r1_score", 0); push("r1_ld_x", 1);
        tick();
        pop_chk(32'(row)); pop_chk(32'(new_x_position)); pop_chk(32'(new_direction));
        pop_chk(32'(new_y_position)); pop_chk(32'(score)); pop_chk(32'(ld_x));
        push("r1_save_x_done", 0);
        tick();
        pop_chk(32'(save_x));

        // Rows 1..6 with overlap: win.
        o = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            push($sformatf("r%0d_save_x", r), 1);
            press();
            pop_chk(32'(save_x));
            if (r < 6) begin
                push($sformatf("r%0d_next_row", r), 32'(r + 1));
                tick();
                pop_chk(32'(row));
                tick();
            end else begin
                push("win_status", 2); push("win_score", 6);
                tick();
                pop_chk(32'(game_status)); pop_chk(32'(score));
            end
        end
        o = 1'b0;
        push("win_p_ignored", 2);
        p = 1'b1; tick(); p = 1'b0;
        pop_chk(32'(game_status));

        // Restart from WIN.
        push("rs_row", 0); push("rs_score", 0); push("rs_chances", 3); push("rs_ld_x", 1);
        press();
        pop_chk(32'(row)); pop_chk(32'(score)); pop_chk(32'(chances_left)); pop_chk(32'(ld_x));
        tick();

        // Climb to row 2, then miss three times.
        press(); tick(); tick();
        o = 1'b1; press(); tick(); tick(); o = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push($sformatf("miss%0d_save_x", i), 0);
            press();
            pop_chk(32'(save_x));
            if (i < 2) begin
                push($sformatf("miss%0d_chances", i), 32'(2 - i));
                push($sformatf("miss%0d_row", i), 2);
                push($sformatf("miss%0d_new_x", i), 0);
                push($sformatf("miss%0d_new_y", i), 72);
                push($sformatf("miss%0d_ld_x", i), 1);
                tick();
                pop_chk(32'(chances_left)); pop_chk(32'(row));
                pop_chk(32'(new_x_position)); pop_chk(32'(new_y_position)); pop_chk(32'(ld_x));
                tick();
            end else begin
                push("lose_status", 3); push("lose_chances", 0);
                tick();
                pop_chk(32'(game_status)); pop_chk(32'(chances_left));
            end
        end

        // Restart from LOSE, then pause with s pulses ignored.
        press(); tick();
        push("pause_enable", 0); push("pause_status", 0);
        p = 1'b1; tick();
        pop_chk(32'(enable)); pop_chk(32'(game_status));
        press(); tick();
        push("pause_s_ignored", 0); push("pause_row", 0);
        pop_chk(32'(game_status)); pop_chk(32'(row));
        p = 1'b0; tick();
        push("resume_enable", 1); push("resume_no_ld_x", 0); push("resume_status", 1);
        p = 1'b1; tick(); p = 1'b0;
        pop_chk(32'(enable)); pop_chk(32'(ld_x)); pop_chk(32'(game_status));
        tick();

        // s and p rise together in MOVE: pause wins, nothing placed.
        push("both_status", 0); push("both_save_x", 0); push("both_row", 0);
        s = 1'b1; p = 1'b1; tick(); s = 1'b0; p = 1'b0;
        pop_chk(32'(game_status)); pop_chk(32'(save_x)); pop_chk(32'(row));
        tick();
        push("both_resume", 1);
        p = 1'b1; tick(); p = 1'b0;
        pop_chk(32'(enable));

        // Reach PLACE on row 2 with score 1, then assert reset mid-cycle.
        press(); tick(); tick();
        o = 1'b1; press(); tick(); tick();
        push("pre_rst_score", 1); push("pre_rst_save_x", 1);
        press();
        pop_chk(32'(score)); pop_chk(32'(save_x));
        push("arst_row", 0); push("arst_score", 0); push("arst_chances", 3);
        push("arst_ld_x", 1); push("arst_new_y", 104);
        #2 reset = 1'b1;
        #1;
        pop_chk(32'(row)); pop_chk(32'(score)); pop_chk(32'(chances_left));
        pop_chk(32'(ld_x)); pop_chk(32'(new_y_position));
        o = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
